writeback_stage_reg: RTL and testbench
======================================

# writeback_stage_reg

Parametrised M-to-W pipeline register for the pipelined Y86-64 core, the successor of the plain writeback register. It adds synchronous reset to a bubble, stall/bubble control from the pipeline control logic, a sticky freeze once an exception status reaches W, and saturating retire/bubble counters for performance debugging. It sits between the memory stage and the register-file write ports. It also drives the processor-level halted flag.

## Interface
- DATA_W, 64, width of valE/valM
- REG_W, 4, register-ID width
- STAT_W, 3, status-code width
- ICODE_W, 4, icode width
- CNT_W, 32, width of each performance counter
- NOP_ICODE, 4'h1, icode loaded on reset/bubble
- RNONE, 4'hF, "no register" ID loaded on reset/bubble
- STAT_AOK, 3'd1, normal status
- STAT_BUB, 3'd0, bubble status
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  synchronous reset, active-high
- W_stall  in  1  hold current contents
- W_bubble  in  1  load a nop bubble
- m_stat  in  STAT_W  status from memory stage
- m_icode  in  ICODE_W  icode from memory stage
- m_valE  in  DATA_W  ALU result
- m_valM  in  DATA_W  memory read data
- m_destE  in  REG_W  destination for valE
- m_destM  in  REG_W  destination for valM
- W_stat, W_icode, W_valE, W_valM, W_destE, W_destM  out  as inputs  registered stage contents
- W_valid  out  1  contents are a real instruction, not a bubble
- halted  out  1  exception status has been captured; W is frozen
- retire_cnt  out  CNT_W  count of loaded instructions with m_stat == STAT_AOK
- bubble_cnt  out  CNT_W  count of cycles in which a bubble was loaded

## Operation
- All outputs are registered. No combinational path from inputs to outputs. Nonblocking updates only.
- Per-edge priority (highest first): rst > frozen > W_bubble > W_stall > load.
- **rst:**
  - W_stat=STAT_BUB, W_icode=NOP_ICODE, W_valE=W_valM=0, W_destE=W_destM=RNONE.
  - W_valid=0, halted=0, both counters=0.
- **frozen** (halted==1):
  - All W_* fields, W_valid and both counters hold.
  - W_stall and W_bubble are ignored.
  - Only rst clears this state.
- **W_bubble:**
  - Load the rst values into the W_* fields; W_valid=0.
  - bubble_cnt += 1. Valid even when W_stall is also high; bubble wins.
- **W_stall:** all fields and counters hold.
- **load:**
  - All m_* fields are copied into the W_* fields.
  - W_valid = (m_stat != STAT_BUB).
  - If m_stat == STAT_AOK: retire_cnt += 1.
  - If m_stat is neither STAT_AOK nor STAT_BUB (HLT/ADR/INS): halted is set on the same edge, and the excepting instruction becomes visible in W together with halted=1.
- A loaded m_stat == STAT_BUB (an upstream bubble) increments neither counter.
- Counters saturate at all-ones. They do not wrap.
- Two states: RUN and FROZEN.
  - RUN -> FROZEN on a load of an exception status.
  - FROZEN -> RUN only on rst.

## Timing
- Latency is 1 cycle: m_* sampled at edge N appears on W_* after edge N.
- Stall: W_* after edge N equals W_* before edge N.
- rst has effect at the edge where it is sampled high, whether in RUN or FROZEN. Outputs show reset values from that edge on.
- rst, W_stall and W_bubble are all sampled only at the rising edge. Glitches between edges have no effect.
- halted rises in the same cycle as W_stat shows the exception code. It never rises without one.

## Test plan
- **Reset:** assert rst for 2 cycles with arbitrary m_* -> W_stat=0, W_icode=1, W_destE=W_destM=4'hF, W_valE=W_valM=0, W_valid=0, halted=0, counters=0.
- **Load/stall:**
  - Load m_stat=1, m_icode=6, m_valE=64'h1234, m_destE=3 -> next cycle W_* match, W_valid=1, retire_cnt=1.
  - Hold W_stall for 3 cycles with changing m_* -> W_* unchanged, retire_cnt=1.
- **Bubble priority:** W_stall=1 and W_bubble=1 together -> W_icode=1, W_stat=0, W_valid=0, bubble_cnt=1, retire_cnt unchanged.
- **Exception freeze:**
  - Load m_stat=2 (HLT), m_icode=0 -> halted=1, W_stat=2.
  - Then 5 cycles of loads, bubbles and stalls -> W_* and counters unchanged.
  - rst -> all reset values, halted=0.
- **Saturation:** with CNT_W=4, load 20 consecutive AOK instructions -> retire_cnt stops at 15. Then 20 bubbles -> bubble_cnt stops at 15.
- **Upstream bubble:** load m_stat=0 -> W_valid=0, neither counter changes, halted stays 0.

Source files
------------

// File: rtl/writeback_stage_reg.sv
// writeback_stage_reg
// M-to-W pipeline register for the pipelined Y86-64 core.
// Adds synchronous reset to a bubble, stall/bubble control, a sticky freeze
// once an exception status is captured in W, and saturating retire/bubble
// performance counters. All outputs come straight from flops.
//
// Per-edge priority, highest first: rst > frozen > W_bubble > W_stall > load.
//
// The two-state control FSM (RUN / FROZEN) is observable on the 'halted'
// output, which is driven directly from the state register.
module writeback_stage_reg #(
    parameter int              DATA_W    = 64,
    parameter int              REG_W     = 4,
    parameter int              STAT_W    = 3,
    parameter int              ICODE_W   = 4,
    parameter int              CNT_W     = 32,
    parameter logic [ICODE_W-1:0] NOP_ICODE = 4'h1,
    parameter logic [REG_W-1:0]   RNONE     = 4'hF,
    parameter logic [STAT_W-1:0]  STAT_AOK  = 3'd1,
    parameter logic [STAT_W-1:0]  STAT_BUB  = 3'd0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               W_stall,
    input  logic               W_bubble,
    input  logic [STAT_W-1:0]  m_stat,
    input  logic [ICODE_W-1:0] m_icode,
    input  logic [DATA_W-1:0]  m_valE,
    input  logic [DATA_W-1:0]  m_valM,
    input  logic [REG_W-1:0]   m_destE,
    input  logic [REG_W-1:0]   m_destM,
    output logic [STAT_W-1:0]  W_stat,
    output logic [ICODE_W-1:0] W_icode,
    output logic [DATA_W-1:0]  W_valE,
    output logic [DATA_W-1:0]  W_valM,
    output logic [REG_W-1:0]   W_destE,
    output logic [REG_W-1:0]   W_destM,
    output logic               W_valid,
    output logic               halted,
    output logic [CNT_W-1:0]   retire_cnt,
    output logic [CNT_W-1:0]   bubble_cnt
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_FROZEN = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t               state_q, state_d;
    logic [STAT_W-1:0]    stat_q,  stat_d;
    logic [ICODE_W-1:0]   icode_q, icode_d;
    logic [DATA_W-1:0]    vale_q,  vale_d;
    logic [DATA_W-1:0]    valm_q,  valm_d;
    logic [REG_W-1:0]     deste_q, deste_d;
    logic [REG_W-1:0]     destm_q, destm_d;
    logic                 valid_q, valid_d;
    logic [CNT_W-1:0]     retire_q, retire_d;
    logic [CNT_W-1:0]     bubble_q, bubble_d;

    // Decoded properties of the incoming memory-stage status.
    logic m_is_aok;
    logic m_is_bub;
    logic m_is_exc;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : (v + CNT_ONE);
    endfunction

    // Classify the memory-stage status: anything not AOK or BUB is an exception.
    always_comb begin
        m_is_aok = (m_stat == STAT_AOK);
        m_is_bub = (m_stat == STAT_BUB);
        m_is_exc = !m_is_aok && !m_is_bub;
    end

    // Next-state and next-contents logic; every register holds by default.
    always_comb begin
        state_d  = state_q;
        stat_d   = stat_q;
        icode_d  = icode_q;
        vale_d   = vale_q;
        valm_d   = valm_q;
        deste_d  = deste_q;
        destm_d  = destm_q;
        valid_d  = valid_q;
        retire_d = retire_q;
        bubble_d = bubble_q;

        case (state_q)
            ST_FROZEN: begin
                // Exception captured: everything holds until rst.
                state_d = ST_FROZEN;
            end
            default: begin
                if (W_bubble) begin
                    // Bubble wins over stall.
                    stat_d   = STAT_BUB;
                    icode_d  = NOP_ICODE;
                    vale_d   = '0;
                    valm_d   = '0;
                    deste_d  = RNONE;
                    destm_d  = RNONE;
                    valid_d  = 1'b0;
                    bubble_d = sat_inc(bubble_q);
                end else if (W_stall) begin
                    // Hold everything (defaults already do this).
                    state_d = ST_RUN;
                end else begin
                    stat_d  = m_stat;
                    icode_d = m_icode;
                    vale_d  = m_valE;
                    valm_d  = m_valM;
                    deste_d = m_destE;
                    destm_d = m_destM;
                    valid_d = !m_is_bub;
                    if (m_is_aok) begin
                        retire_d = sat_inc(retire_q);
                    end
                    // The excepting instruction lands in W on the same edge
                    // that the freeze takes hold.
                    if (m_is_exc) begin
                        state_d = ST_FROZEN;
                    end
                end
            end
        endcase
    end

    // State and contents registers with synchronous reset to a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            stat_q   <= STAT_BUB;
            icode_q  <= NOP_ICODE;
            vale_q   <= '0;
            valm_q   <= '0;
            deste_q  <= RNONE;
            destm_q  <= RNONE;
            valid_q  <= 1'b0;
            retire_q <= '0;
            bubble_q <= '0;
        end else begin
            state_q  <= state_d;
            stat_q   <= stat_d;
            icode_q  <= icode_d;
            vale_q   <= vale_d;
            valm_q   <= valm_d;
            deste_q  <= deste_d;
            destm_q  <= destm_d;
            valid_q  <= valid_d;
            retire_q <= retire_d;
            bubble_q <= bubble_d;
        end
    end

    // Outputs are the register contents directly.
    always_comb begin
        W_stat     = stat_q;
        W_icode    = icode_q;
        W_valE     = vale_q;
        W_valM     = valm_q;
        W_destE    = deste_q;
        W_destM    = destm_q;
        W_valid    = valid_q;
        halted     = (state_q == ST_FROZEN);
        retire_cnt = retire_q;
        bubble_cnt = bubble_q;
    end

endmodule

// File: tb/tb_writeback_stage_reg.sv
// Directed testbench for writeback_stage_reg. Two instances share the same
// stimulus: one with 32-bit counters and one with 4-bit counters, so that
// saturation can be seen on the narrow one while the wide one keeps counting.
module tb_writeback_stage_reg;

    logic        clk;
    logic        rst;
    logic        w_stall;
    logic        w_bubble;
    logic [2:0]  m_stat;
    logic [3:0]  m_icode;
    logic [63:0] m_vale;
    logic [63:0] m_valm;
    logic [3:0]  m_deste;
    logic [3:0]  m_destm;

    logic [2:0]  w_stat;
    logic [3:0]  w_icode;
    logic [63:0] w_vale;
    logic [63:0] w_valm;
    logic [3:0]  w_deste;
    logic [3:0]  w_destm;
    logic        w_valid;
    logic        halted;
    logic [31:0] retire_cnt;
    logic [31:0] bubble_cnt;

    logic [2:0]  s_stat;
    logic [3:0]  s_icode;
    logic [63:0] s_vale;
    logic [63:0] s_valm;
    logic [3:0]  s_deste;
    logic [3:0]  s_destm;
    logic        s_valid;
    logic        s_halted;
    logic [3:0]  s_retire;
    logic [3:0]  s_bubble;

    int n_tests;
    int n_fail;

    writeback_stage_reg u_dut (
        .clk        (clk),
        .rst        (rst),
        .W_stall    (w_stall),
        .W_bubble   (w_bubble),
        .m_stat     (m_stat),
        .m_icode    (m_icode),
        .m_valE     (m_vale),
        .m_valM     (m_valm),
        .m_destE    (m_deste),
        .m_destM    (m_destm),
        .W_stat     (w_stat),
        .W_icode    (w_icode),
        .W_valE     (w_vale),
        .W_valM     (w_valm),
        .W_destE    (w_deste),
        .W_destM    (w_destm),
        .W_valid    (w_valid),
        .halted     (halted),
        .retire_cnt (retire_cnt),
        .bubble_cnt (bubble_cnt)
    );

    writeback_stage_reg #(.CNT_W(4)) u_sat (
        .clk        (clk),
        .rst        (rst),
        .W_stall    (w_stall),
        .W_bubble   (w_bubble),
        .m_stat     (m_stat),
        .m_icode    (m_icode),
        .m_valE     (m_vale),
        .m_valM     (m_valm),
        .m_destE    (m_deste),
        .m_destM    (m_destm),
        .W_stat     (s_stat),
        .W_icode    (s_icode),
        .W_valE     (s_vale),
        .W_valM     (s_valm),
        .W_destE    (s_deste),
        .W_destM    (s_destm),
        .W_valid    (s_valid),
        .halted     (s_halted),
        .retire_cnt (s_retire),
        .bubble_cnt (s_bubble)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Single comparison point for every check.
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input logic [2:0] st, input logic [3:0] ic, input logic [63:0] ve,
                         input logic [63:0] vm, input logic [3:0] de, input logic [3:0] dm);
        m_stat  = st;
        m_icode = ic;
        m_vale  = ve;
        m_valm  = vm;
        m_deste = de;
        m_destm = dm;
    endtask

    task automatic set_ctl(input logic r, input logic st, input logic bb);
        rst      = r;
        w_stall  = st;
        w_bubble = bb;
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_m();
        set_m(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), {$urandom, $urandom},
              {$urandom, $urandom}, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_stat"},   64'(w_stat),     64'd0);
        check_eq({tag, "_icode"},  64'(w_icode),    64'd1);
        check_eq({tag, "_valE"},   w_vale,          64'd0);
        check_eq({tag, "_valM"},   w_valm,          64'd0);
        check_eq({tag, "_destE"},  64'(w_deste),    64'hF);
        check_eq({tag, "_destM"},  64'(w_destm),    64'hF);
        check_eq({tag, "_valid"},  64'(w_valid),    64'd0);
        check_eq({tag, "_halted"}, 64'(halted),     64'd0);
        check_eq({tag, "_retire"}, 64'(retire_cnt), 64'd0);
        check_eq({tag, "_bubble"}, 64'(bubble_cnt), 64'd0);
        check_eq({tag, "_s_retire"}, 64'(s_retire), 64'd0);
        check_eq({tag, "_s_bubble"}, 64'(s_bubble), 64'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        set_ctl(1'b1, 1'b0, 1'b0);
        rand_m();
        #2;

        // Reset held for two edges with arbitrary memory-stage inputs.
        for (int i = 0; i < 2; i++) begin
            rand_m();
            step();
        end
        check_reset_values("reset");

        // Plain load of an AOK instruction.
        set_ctl(1'b0, 1'b0, 1'b0);
        set_m(3'd1, 4'd6, 64'h1234, 64'h55AA, 4'd3, 4'hF);
        step();
        check_eq("load_stat",   64'(w_stat),     64'd1);
        check_eq("load_icode",  64'(w_icode),    64'd6);
        check_eq("load_valE",   w_vale,          64'h1234);
        check_eq("load_valM",   w_valm,          64'h55AA);
        check_eq("load_destE",  64'(w_deste),    64'd3);
        check_eq("load_destM",  64'(w_destm),    64'hF);
        check_eq("load_valid",  64'(w_valid),    64'd1);
        check_eq("load_retire", 64'(retire_cnt), 64'd1);
        check_eq("load_bubble", 64'(bubble_cnt), 64'd0);
        check_eq("load_halted", 64'(halted),     64'd0);

        // Stall for three edges while the memory stage keeps changing.
        set_ctl(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            set_m(3'd1, 4'(i + 2), 64'(i + 100), 64'(i), 4'(i), 4'(i + 5));
            step();
            check_eq("stall_icode",  64'(w_icode),    64'd6);
            check_eq("stall_valE",   w_vale,          64'h1234);
            check_eq("stall_destE",  64'(w_deste),    64'd3);
            check_eq("stall_retire", 64'(retire_cnt), 64'd1);
        end

        // Stall and bubble together: the bubble wins.
        set_ctl(1'b0, 1'b1, 1'b1);
        step();
        check_eq("bub_icode",  64'(w_icode),    64'd1);
        check_eq("bub_stat",   64'(w_stat),     64'd0);
        check_eq("bub_valE",   w_vale,          64'd0);
        check_eq("bub_destE",  64'(w_deste),    64'hF);
        check_eq("bub_destM",  64'(w_destm),    64'hF);
        check_eq("bub_valid",  64'(w_valid),    64'd0);
        check_eq("bub_bubble", 64'(bubble_cnt), 64'd1);
        check_eq("bub_retire", 64'(retire_cnt), 64'd1);

        // Upstream bubble loaded: copied through but counts nothing.
        set_ctl(1'b0, 1'b0, 1'b0);
        set_m(3'd0, 4'd3, 64'd77, 64'd0, 4'd2, 4'd4);
        step();
        check_eq("ubub_valid",  64'(w_valid),    64'd0);
        check_eq("ubub_icode",  64'(w_icode),    64'd3);
        check_eq("ubub_valE",   w_vale,          64'd77);
        check_eq("ubub_retire", 64'(retire_cnt), 64'd1);
        check_eq("ubub_bubble", 64'(bubble_cnt), 64'd1);
        check_eq("ubub_halted", 64'(halted),     64'd0);

        // HLT reaches W: visible together with halted on the same edge.
        set_m(3'd2, 4'd0, 64'hDEAD, 64'hBEEF, 4'd7, 4'd8);
        step();
        check_eq("exc_halted", 64'(halted),     64'd1);
        check_eq("exc_stat",   64'(w_stat),     64'd2);
        check_eq("exc_icode",  64'(w_icode),    64'd0);
        check_eq("exc_valE",   w_vale,          64'hDEAD);
        check_eq("exc_valid",  64'(w_valid),    64'd1);
        check_eq("exc_retire", 64'(retire_cnt), 64'd1);

        // Frozen: loads, bubbles and stalls are all ignored.
        for (int i = 0; i < 5; i++) begin
            set_ctl(1'b0, 1'(i % 2), 1'(i >= 2 && i <= 3));
            set_m(3'd1, 4'(i + 9), 64'(i + 1), 64'(i + 2), 4'(i), 4'(i));
            step();
            check_eq("frz_stat",   64'(w_stat),     64'd2);
            check_eq("frz_icode",  64'(w_icode),    64'd0);
            check_eq("frz_valE",   w_vale,          64'hDEAD);
            check_eq("frz_destM",  64'(w_destm),    64'd8);
            check_eq("frz_valid",  64'(w_valid),    64'd1);
            check_eq("frz_halted", 64'(halted),     64'd1);
            check_eq("frz_retire", 64'(retire_cnt), 64'd1);
            check_eq("frz_bubble", 64'(bubble_cnt), 64'd1);
        end

        // Reset out of the frozen state.
        set_ctl(1'b1, 1'b0, 1'b0);
        step();
        check_reset_values("frz_reset");

        // Saturation: 20 AOK loads, then 20 bubbles.
        set_ctl(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            set_m(3'd1, 4'd2, 64'(i), 64'd0, 4'd1, 4'hF);
            step();
            if (i == 13) begin
                check_eq("sat_retire_14", 64'(s_retire), 64'd14);
            end
        end
        check_eq("sat_retire_small", 64'(s_retire),   64'd15);
        check_eq("sat_retire_wide",  64'(retire_cnt), 64'd20);
        check_eq("sat_last_valE",    w_vale,          64'd19);
        check_eq("sat_halted",       64'(s_halted),   64'd0);

        set_ctl(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step();
        end
        check_eq("sat_bubble_small", 64'(s_bubble),   64'd15);
        check_eq("sat_bubble_wide",  64'(bubble_cnt), 64'd20);
        check_eq("sat_retire_hold",  64'(s_retire),   64'd15);
        check_eq("sat_bub_valid",    64'(s_valid),    64'd0);

        // ADR exception on the narrow instance's path as well.
        set_ctl(1'b0, 1'b0, 1'b0);
        set_m(3'd3, 4'd5, 64'h42, 64'd0, 4'd6, 4'd6);
        step();
        check_eq("adr_halted",   64'(s_halted),   64'd1);
        check_eq("adr_stat",     64'(s_stat),     64'd3);
        check_eq("adr_retire",   64'(retire_cnt), 64'd20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
